// File: rtl/mem_responder_if.sv
// memory_valid/memory_ready bus between an initiator (arbiter) and mem_responder.
interface mem_responder_if;
    logic        memory_valid;
    logic        memory_instr;
    logic [31:0] memory_addr;
    logic [31:0] memory_wdata;
    logic [3:0]  memory_wstrb;
    logic [31:0] memory_rdata;
    logic        memory_ready;

    modport master (
        output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
        input  memory_rdata, memory_ready
    );

    modport slave (
        input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
        output memory_rdata, memory_ready
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM target with byte strobes and programmable wait states.
// Optional: MEM_RESPONDER_IFETCH_FAST_EN gives instruction fetches a one-cycle latency.
module mem_responder #(
    parameter int unsigned DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic           clock,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LIMIT     = 33'(DEPTH) << 2;
    localparam logic [3:0]  LOAD_FULL = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        instr_q;
    logic [31:0] rdata_q;
    logic [31:0] mem [DEPTH];

    logic             accept;
    logic             fast;
    logic             enter_resp;
    logic [31:0]      acc_addr, acc_wdata;
    logic [3:0]       acc_wstrb;
    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] index;
    logic             unused_instr;

    always_comb begin
        accept = bus.memory_valid && ((state_q == IDLE) || (state_q == RESP));
`ifdef MEM_RESPONDER_IFETCH_FAST_EN
        fast = bus.memory_instr || (LATENCY == 1);
`else
        fast = (LATENCY == 1);
`endif
        state_d    = state_q;
        count_d    = count_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = fast ? RESP : WAIT;
                    count_d    = fast ? 4'd0 : LOAD_FULL;
                    enter_resp = fast;
                end
            end
            WAIT: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (accept) begin
                    state_d    = fast ? RESP : WAIT;
                    count_d    = fast ? 4'd0 : LOAD_FULL;
                    enter_resp = fast;
                end else begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // A single-cycle access commits on the accepting edge, before the request
    // registers hold it, so the bus is used directly in that case.
    always_comb begin
        if (accept) begin
            acc_addr  = bus.memory_addr;
            acc_wdata = bus.memory_wdata;
            acc_wstrb = bus.memory_wstrb;
        end else begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_wstrb = wstrb_q;
        end
        offset   = acc_addr - BASE_ADDR;
        in_range = ({1'b0, offset} < LIMIT);
        index    = offset[IDX_W+1:2];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            instr_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (accept) begin
                addr_q  <= bus.memory_addr;
                wdata_q <= bus.memory_wdata;
                wstrb_q <= bus.memory_wstrb;
                instr_q <= bus.memory_instr;
            end
            if (enter_resp && (acc_wstrb == '0) && in_range) begin
                rdata_q <= mem[index];
            end else begin
                rdata_q <= '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && enter_resp && in_range) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (acc_wstrb[i]) begin
                    mem[index][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        bus.memory_ready = (state_q == RESP);
        bus.memory_rdata = rdata_q;
        unused_instr     = instr_q;
    end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances (LATENCY 1..4) checked against a
// cycle-timing and associative-array memory model driven by directed and random requests.
module tb_mem_responder;
    localparam int unsigned DEPTH = 4096;
    localparam logic [31:0] BASE3 = 32'h8000_0000;
`ifdef MEM_RESPONDER_IFETCH_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          gap;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        drv_valid, drv_instr;
    logic [31:0] drv_addr, drv_wdata;
    logic [3:0]  drv_wstrb;
    int          sel;
    logic        rdy  [4];
    logic [31:0] rdat [4];

    int          n_tests = 0;
    int          n_fail  = 0;
    bit [31:0]   mdl [int];
    req_t        rq [$];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_responder_if bus ();
        assign bus.memory_valid = drv_valid && (sel == g);
        assign bus.memory_instr = drv_instr;
        assign bus.memory_addr  = drv_addr;
        assign bus.memory_wdata = drv_wdata;
        assign bus.memory_wstrb = drv_wstrb;
        mem_responder #(
            .DEPTH     (DEPTH),
            .BASE_ADDR ((g == 3) ? BASE3 : 32'h0),
            .LATENCY   (g + 1)
        ) u_dut (
            .clock (clk),
            .reset (rst),
            .bus   (bus)
        );
        assign rdy[g]  = bus.memory_ready;
        assign rdat[g] = bus.memory_rdata;
    end

    function automatic logic [31:0] base_of(input int k);
        return (k == 3) ? BASE3 : 32'h0;
    endfunction

    function automatic int lat_of(input int k, input logic instr);
        return (FAST && instr) ? 1 : k + 1;
    endfunction

    // Expected read data for one access; writes update the model and return 0.
    function automatic logic [31:0] model_access(input int k, input req_t r);
        logic [31:0] off;
        logic [31:0] w;
        int key;
        off = r.addr - base_of(k);
        if (off >= DEPTH * 4) return 32'h0;
        key = k * 2 * DEPTH + int'(off >> 2);
        if (r.wstrb == 4'h0) return mdl.exists(key) ? mdl[key] : 32'h0;
        w = mdl.exists(key) ? mdl[key] : 32'h0;
        for (int b = 0; b < 4; b++)
            if (r.wstrb[b]) w[8*b +: 8] = r.wdata[8*b +: 8];
        mdl[key] = w;
        return 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic instr, input logic [31:0] a, input logic [31:0] w,
                        input logic [3:0] s, input int gap);
        req_t r;
        r.instr = instr;
        r.addr  = a;
        r.wdata = w;
        r.wstrb = s;
        r.gap   = gap;
        rq.push_back(r);
    endtask

    // Plays the queued requests on DUT k as a holding initiator; gap 0 means
    // the next request is presented in the ready cycle of the previous one.
    task automatic run_seq(input int k);
        int lat;
        logic [31:0] exp_rd;
        sel = k;
        foreach (rq[j]) begin
            if (rq[j].gap > 0) begin
                drv_valid = 1'b0;
                for (int g2 = 0; g2 < rq[j].gap; g2++) begin
                    tick();
                    chk($sformatf("k%0d_r%0d_idle_ready", k, j), 32'(rdy[k]), 32'd0);
                    chk($sformatf("k%0d_r%0d_idle_rdata", k, j), rdat[k], 32'd0);
                end
            end
            drv_valid = 1'b1;
            drv_instr = rq[j].instr;
            drv_addr  = rq[j].addr;
            drv_wdata = rq[j].wdata;
            drv_wstrb = rq[j].wstrb;
            lat    = lat_of(k, rq[j].instr);
            exp_rd = model_access(k, rq[j]);
            for (int c = 1; c <= lat; c++) begin
                tick();
                if (c < lat) begin
                    chk($sformatf("k%0d_r%0d_wait_ready", k, j), 32'(rdy[k]), 32'd0);
                    chk($sformatf("k%0d_r%0d_wait_rdata", k, j), rdat[k], 32'd0);
                end else begin
                    chk($sformatf("k%0d_r%0d_resp_ready", k, j), 32'(rdy[k]), 32'd1);
                    chk($sformatf("k%0d_r%0d_resp_rdata", k, j), rdat[k], exp_rd);
                    last_rd = rdat[k];
                end
            end
        end
        drv_valid = 1'b0;
        rq.delete();
    endtask

    task automatic aborted_access(input logic [3:0] s, input logic [31:0] w);
        sel       = 3;
        drv_valid = 1'b1;
        drv_instr = 1'b0;
        drv_addr  = BASE3;
        drv_wdata = w;
        drv_wstrb = s;
        repeat (2) begin
            tick();
            chk("abort_wait_ready", 32'(rdy[3]), 32'd0);
        end
        rst = 1'b1;
        repeat (2) begin
            tick();
            chk("abort_rst_ready", 32'(rdy[3]), 32'd0);
            chk("abort_rst_rdata", rdat[3], 32'd0);
        end
        rst       = 1'b0;
        drv_valid = 1'b0;
        repeat (4) begin
            tick();
            chk("abort_after_ready", 32'(rdy[3]), 32'd0);
            chk("abort_after_rdata", rdat[3], 32'd0);
        end
    endtask

    initial begin
        logic [31:0] pool [11];
        int p;
        rst       = 1'b1;
        drv_valid = 1'b0;
        drv_instr = 1'b0;
        drv_addr  = '0;
        drv_wdata = '0;
        drv_wstrb = '0;
        sel       = 0;
        last_rd   = '0;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("k%0d_reset_ready", k), 32'(rdy[k]), 32'd0);
            chk($sformatf("k%0d_reset_rdata", k), rdat[k], 32'd0);
        end
        rst = 1'b0;

        // Reset during wait states drops the pending read and an uncommitted write
        push(1'b0, BASE3, 32'hDEAD_BEEF, 4'hF, 1);
        run_seq(3);
        aborted_access(4'h0, 32'h0);
        aborted_access(4'hF, 32'h1234_5678);
        push(1'b0, BASE3, 32'h0, 4'h0, 1);
        run_seq(3);
        chk("t1_preload_read", last_rd, 32'hDEAD_BEEF);

        // Byte-strobed merge, LATENCY=2
        push(1'b0, 32'h10, 32'h1122_3344, 4'hF, 1);
        push(1'b0, 32'h10, 32'hAABB_CCDD, 4'h5, 0);
        push(1'b0, 32'h10, 32'h0, 4'h0, 0);
        run_seq(1);
        chk("t2_merged", last_rd, 32'h11BB_33DD);

        // Back-to-back reads, LATENCY=1
        push(1'b0, 32'h0, 32'hA0A0_0000, 4'hF, 1);
        push(1'b0, 32'h4, 32'hA0A0_0004, 4'hF, 0);
        push(1'b0, 32'h8, 32'hA0A0_0008, 4'hF, 0);
        push(1'b0, 32'h0, 32'h0, 4'h0, 1);
        push(1'b0, 32'h4, 32'h0, 4'h0, 0);
        push(1'b0, 32'h8, 32'h0, 4'h0, 0);
        run_seq(0);
        chk("t3_last_word", last_rd, 32'hA0A0_0008);

        // Out of range write dropped, still acknowledged
        push(1'b0, 32'h0, 32'h0102_0304, 4'hF, 1);
        push(1'b0, 32'h4000, 32'hFFFF_FFFF, 4'hF, 0);
        push(1'b0, 32'h4000, 32'h0, 4'h0, 0);
        run_seq(1);
        chk("t4_oor_rdata", last_rd, 32'h0);
        push(1'b0, 32'h0, 32'h0, 4'h0, 0);
        run_seq(1);
        chk("t4_word0_kept", last_rd, 32'h0102_0304);

        // Low address bits ignored
        push(1'b0, 32'h10, 32'h0BAD_F00D, 4'hF, 1);
        push(1'b0, 32'h13, 32'h0, 4'h0, 0);
        run_seq(1);
        chk("t5_misaligned", last_rd, 32'h0BAD_F00D);

        // Ifetch followed by a data read, LATENCY=3
        push(1'b0, 32'h20, 32'hCAFE_F00D, 4'hF, 1);
        push(1'b0, 32'h24, 32'h1357_9BDF, 4'hF, 0);
        push(1'b1, 32'h20, 32'h0, 4'h0, 1);
        push(1'b0, 32'h24, 32'h0, 4'h0, 0);
        run_seq(2);
        chk("t6_data_read", last_rd, 32'h1357_9BDF);

        // Random traffic over a small pool including both range edges
        for (int i = 0; i < 8; i++) pool[i] = 32'h100 + 32'(4 * i);
        pool[8]  = (DEPTH - 1) * 4;
        pool[9]  = DEPTH * 4;
        pool[10] = 32'hFFFF_FFFC;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 9; i++)
                push(1'b0, base_of(k) + pool[i], $urandom, 4'hF, $urandom_range(0, 1));
            for (int i = 0; i < 40; i++) begin
                p = $urandom_range(0, 10);
                push(1'($urandom_range(0, 1)),
                     base_of(k) + pool[p] + 32'($urandom_range(0, 3)),
                     $urandom,
                     ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15)),
                     $urandom_range(0, 2));
            end
            run_seq(k);
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
